// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: fp16 pixel format,
// window array type and small sizing helpers used by the window generator
// and the convolution wrappers.
package conv_pkg;

    localparam int FP16_EXP_WIDTH  = 5;
    localparam int FP16_FRAC_WIDTH = 10;
    localparam int FP_WIDTH_REG    = 1 + FP16_EXP_WIDTH + FP16_FRAC_WIDTH;

    // Largest window the generator supports in either direction
    localparam int WINDOW_MAX = 8;

    typedef logic [FP_WIDTH_REG-1:0] fp16_t;
    typedef fp16_t fp16_window_t [WINDOW_MAX][WINDOW_MAX];

    // Address width for a storage of the given depth, never narrower than 1 bit
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: register file with combinational read
// and synchronous write. Contents are deliberately not reset; the window
// generator's validity rules keep stale entries from ever reaching an output.
module line_buffer #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int FP_WIDTH_REG = conv_pkg::FP_WIDTH_REG,
    localparam int AW          = conv_pkg::addr_width(IMAGE_WIDTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [AW-1:0]           addr,
    input  logic [FP_WIDTH_REG-1:0] wr_data,
    output logic [FP_WIDTH_REG-1:0] rd_data
);

    logic [FP_WIDTH_REG-1:0] mem [IMAGE_WIDTH];

    assign rd_data = mem[addr];

    // Store the incoming column value; the read above still sees the old one
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_generator_fp16.sv
// Sliding window generator for raster-order fp16 pixels. Keeps
// WINDOW_HEIGHT-1 line buffers and a WINDOW_HEIGHT x WINDOW_WIDTH register
// window; each accepted pixel shifts the window left by one column.
// Optional build macro WINDOW_GENERATOR_ZERO_PAD_EN: emit a window for every
// accepted pixel, forcing out-of-image elements to +0.0.
module window_generator_fp16
    import conv_pkg::*;
#(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int WINDOW_WIDTH  = 2,
    parameter int WINDOW_HEIGHT = 1,
    parameter int IMAGE_WIDTH   = 640,
    localparam int PIX_W        = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PIX_W-1:0] pixel_i,
    input  logic [15:0]      col_i,
    input  logic [15:0]      row_i,
    input  logic             valid_i,
    output logic [PIX_W-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH],
    output logic [15:0]      col_o,
    output logic [15:0]      row_o,
    output logic             valid_o
);

    localparam int AW = addr_width(IMAGE_WIDTH);

    logic             accept;
    logic             window_full;
    logic [AW-1:0]    lb_addr;
    logic [PIX_W-1:0] lb_rd [WINDOW_HEIGHT];
    logic [PIX_W-1:0] win   [WINDOW_HEIGHT][WINDOW_WIDTH];

    // Columns past the line end are ignored entirely, as are bubbles
    assign accept  = valid_i && ({16'b0, col_i} < 32'(IMAGE_WIDTH));
    assign lb_addr = col_i[AW-1:0];

    // Slot 0 is the live pixel so that slot k is always the pixel k rows up
    assign lb_rd[0] = pixel_i;

    genvar k;
    generate
        for (k = 1; k < WINDOW_HEIGHT; k++) begin : g_lb
            line_buffer #(
                .IMAGE_WIDTH  (IMAGE_WIDTH),
                .FP_WIDTH_REG (PIX_W)
            ) u_line_buffer (
                .clk     (clk_i),
                .wr_en   (accept),
                .addr    (lb_addr),
                .wr_data (lb_rd[k-1]),
                .rd_data (lb_rd[k])
            );
        end
    endgenerate

`ifdef WINDOW_GENERATOR_ZERO_PAD_EN
    assign window_full = 1'b1;
`else
    assign window_full = (int'({16'b0, col_i}) >= WINDOW_WIDTH - 1) &&
                         (int'({16'b0, row_i}) >= WINDOW_HEIGHT - 1);
`endif

    // Shift every window row left and pull the new right column from the line buffers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < WINDOW_HEIGHT; r++) begin
                for (int c = 0; c < WINDOW_WIDTH; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WINDOW_HEIGHT; r++) begin
                for (int c = 0; c < WINDOW_WIDTH - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][WINDOW_WIDTH-1] <= lb_rd[WINDOW_HEIGHT-1-r];
            end
        end
    end

    // Coordinates of the newest window pixel and its validity, one cycle behind the input
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            col_o   <= '0;
            row_o   <= '0;
        end else begin
            valid_o <= accept && window_full;
            if (accept) begin
                col_o <= col_i;
                row_o <= row_i;
            end
        end
    end

`ifdef WINDOW_GENERATOR_ZERO_PAD_EN
    // Replace elements whose source lies left of or above the image with +0.0
    always_comb begin
        for (int r = 0; r < WINDOW_HEIGHT; r++) begin
            for (int c = 0; c < WINDOW_WIDTH; c++) begin
                window_o[r][c] = win[r][c];
                if ((int'({16'b0, col_o}) < WINDOW_WIDTH - 1 - c) ||
                    (int'({16'b0, row_o}) < WINDOW_HEIGHT - 1 - r)) begin
                    window_o[r][c] = '0;
                end
            end
        end
    end
`else
    assign window_o = win;
`endif

endmodule

// File: tb/tb_window_generator_fp16.sv
// Directed bench for window_generator_fp16: a 2x1 and a 2x2 instance share
// one pixel stream; expected windows come from the frame contents the bench
// itself drove.
module tb_window_generator_fp16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pixel;
    logic [15:0] col;
    logic [15:0] row;
    logic        valid;

    logic [15:0] win_a [1][2];
    logic [15:0] col_a, row_a;
    logic        valid_a;
    logic [15:0] win_b [2][2];
    logic [15:0] col_b, row_b;
    logic        valid_b;

    int error_count = 0;
    int check_count = 0;
    int a_valid_cnt = 0;
    int b_valid_cnt = 0;
    bit b_seen;
    int b_first_col, b_first_row;

    logic [15:0] pix_mem [8][8];
    logic [15:0] row_px  [4];

    always #5 clk = ~clk;

    window_generator_fp16 #(
        .WINDOW_WIDTH (2), .WINDOW_HEIGHT (1), .IMAGE_WIDTH (640)
    ) dut_a (
        .clk_i (clk), .rst_i (rst), .pixel_i (pixel), .col_i (col), .row_i (row),
        .valid_i (valid), .window_o (win_a), .col_o (col_a), .row_o (row_a), .valid_o (valid_a)
    );

    window_generator_fp16 #(
        .WINDOW_WIDTH (2), .WINDOW_HEIGHT (2), .IMAGE_WIDTH (640)
    ) dut_b (
        .clk_i (clk), .rst_i (rst), .pixel_i (pixel), .col_i (col), .row_i (row),
        .valid_i (valid), .window_o (win_b), .col_o (col_b), .row_o (row_b), .valid_o (valid_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one input cycle and leave outputs ready to sample 1 time unit after the edge
    task automatic applyStimulus(input int c, input int r, input logic [15:0] px, input bit v);
        col   = 16'(c);
        row   = 16'(r);
        pixel = px;
        valid = v;
        if (v && c < 8 && r < 8) pix_mem[r][c] = px;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_px(input int r, input int c);
        if (r < 0 || c < 0) return 16'h0000;
        return pix_mem[r][c];
    endfunction

    // Compare both instances against the window the drawn frame implies
    task automatic check_pixel(input int c, input int r, input bit acc);
        bit va;
        bit vb;
`ifdef WINDOW_GENERATOR_ZERO_PAD_EN
        va = acc;
        vb = acc;
`else
        va = acc && (c >= 1);
        vb = acc && (c >= 1) && (r >= 1);
`endif
        checkOutput("a_valid", 32'(valid_a), 32'(va));
        checkOutput("b_valid", 32'(valid_b), 32'(vb));
        if (valid_a === 1'b1) a_valid_cnt++;
        if (valid_b === 1'b1) begin
            b_valid_cnt++;
            if (!b_seen) begin
                b_seen      = 1'b1;
                b_first_col = int'(col_b);
                b_first_row = int'(row_b);
            end
        end
        if (va) begin
            checkOutput("a_col", 32'(col_a), 32'(c));
            checkOutput("a_row", 32'(row_a), 32'(r));
            for (int wc = 0; wc < 2; wc++)
                checkOutput("a_win", 32'(win_a[0][wc]), 32'(model_px(r, c - 1 + wc)));
        end
        if (vb) begin
            checkOutput("b_col", 32'(col_b), 32'(c));
            checkOutput("b_row", 32'(row_b), 32'(r));
            for (int wr = 0; wr < 2; wr++)
                for (int wc = 0; wc < 2; wc++)
                    checkOutput("b_win", 32'(win_b[wr][wc]), 32'(model_px(r - 1 + wr, c - 1 + wc)));
        end
    endtask

    task automatic send_pixel(input int c, input int r, input logic [15:0] px);
        applyStimulus(c, r, px, 1'b1);
        check_pixel(c, r, 1'b1);
    endtask

    task automatic send_bubble();
        applyStimulus(0, 0, 16'hFFFF, 1'b0);
        check_pixel(0, 0, 1'b0);
    endtask

    task automatic check_reset_zero();
        checkOutput("rst_a_valid", 32'(valid_a), 32'd0);
        checkOutput("rst_a_col", 32'(col_a), 32'd0);
        checkOutput("rst_a_row", 32'(row_a), 32'd0);
        checkOutput("rst_b_valid", 32'(valid_b), 32'd0);
        checkOutput("rst_b_col", 32'(col_b), 32'd0);
        checkOutput("rst_b_row", 32'(row_b), 32'd0);
        for (int wc = 0; wc < 2; wc++) begin
            checkOutput("rst_a_win", 32'(win_a[0][wc]), 32'd0);
            for (int wr = 0; wr < 2; wr++)
                checkOutput("rst_b_win", 32'(win_b[wr][wc]), 32'd0);
        end
    endtask

    // 4x3 frame with pixel = row*4+col, optionally with random 0-3 cycle bubbles
    task automatic run_frame_b(input bit gaps);
        b_valid_cnt = 0;
        b_seen      = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (gaps) repeat ($urandom_range(0, 3)) send_bubble();
                send_pixel(c, r, 16'(r * 4 + c));
            end
        end
`ifdef WINDOW_GENERATOR_ZERO_PAD_EN
        checkOutput("b_valid_count", 32'(b_valid_cnt), 32'd12);
`else
        checkOutput("b_valid_count", 32'(b_valid_cnt), 32'd6);
        checkOutput("b_first_col", 32'(b_first_col), 32'd1);
        checkOutput("b_first_row", 32'(b_first_row), 32'd1);
`endif
    endtask

    initial begin
        row_px[0] = 16'h3C00;
        row_px[1] = 16'h4000;
        row_px[2] = 16'h4200;
        row_px[3] = 16'h4400;
        rst   = 1'b1;
        pixel = '0;
        col   = '0;
        row   = '0;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // A pixel offered during reset must be ignored
        pixel = 16'h3C00;
        col   = 16'd1;
        valid = 1'b1;
        @(posedge clk);
        #1;
        check_reset_zero();
        valid = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;

        // Frame A: fp16 row pattern, two rows of four
        a_valid_cnt = 0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                send_pixel(c, r, row_px[c]);
                if (r == 0 && c == 1) begin
                    checkOutput("a_first_w0", 32'(win_a[0][0]), 32'h3C00);
                    checkOutput("a_first_w1", 32'(win_a[0][1]), 32'h4000);
                    checkOutput("a_first_col", 32'(col_a), 32'd1);
                end
            end
        end
`ifdef WINDOW_GENERATOR_ZERO_PAD_EN
        checkOutput("a_valid_count", 32'(a_valid_cnt), 32'd8);
`else
        checkOutput("a_valid_count", 32'(a_valid_cnt), 32'd6);
`endif

        // Frame B gap-free, with an out-of-line column slipped in after (1,1)
        b_valid_cnt = 0;
        b_seen      = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                send_pixel(c, r, 16'(r * 4 + c));
                if (r == 1 && c == 1) begin
                    checkOutput("b_11_w00", 32'(win_b[0][0]), 32'd0);
                    checkOutput("b_11_w01", 32'(win_b[0][1]), 32'd1);
                    checkOutput("b_11_w10", 32'(win_b[1][0]), 32'd4);
                    checkOutput("b_11_w11", 32'(win_b[1][1]), 32'd5);
                    applyStimulus(640, 1, 16'h7BFF, 1'b1);
                    check_pixel(640, 1, 1'b0);
                end
            end
        end
`ifdef WINDOW_GENERATOR_ZERO_PAD_EN
        checkOutput("b_valid_count", 32'(b_valid_cnt), 32'd12);
`else
        checkOutput("b_valid_count", 32'(b_valid_cnt), 32'd6);
`endif

        // Same frame with bubbles must give the same windows
        run_frame_b(1'b1);

        // Reset in the middle of row 1, then restart the frame
        for (int c = 0; c < 4; c++) send_pixel(c, 0, 16'(c));
        for (int c = 0; c < 2; c++) send_pixel(c, 1, 16'(4 + c));
        col   = 16'd2;
        row   = 16'd1;
        pixel = 16'd6;
        valid = 1'b1;
        rst   = 1'b1;
        #2;
        check_reset_zero();
        @(posedge clk);
        #1;
        check_reset_zero();
        rst   = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        run_frame_b(1'b0);

`ifdef WINDOW_GENERATOR_ZERO_PAD_EN
        // Padded corner window right after reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, 16'h3C00, 1'b1);
        checkOutput("pad_valid", 32'(valid_b), 32'd1);
        checkOutput("pad_w00", 32'(win_b[0][0]), 32'd0);
        checkOutput("pad_w01", 32'(win_b[0][1]), 32'd0);
        checkOutput("pad_w10", 32'(win_b[1][0]), 32'd0);
        checkOutput("pad_w11", 32'(win_b[1][1]), 32'h3C00);
`endif

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
